// File: rtl/read_return_router.sv
// Read return router: buffers read_back returns in a FIFO and hands each head entry to one receiver.
// Latency: a return pushed at edge N is presented after edge N. Throughput is one push and one pop per cycle.
// Backpressure: a stalled receiver blocks the head. halt is registered and warns the source HALT_MARGIN entries early.
// Optional statistics counters are built when READ_RETURN_ROUTER_STATS_EN is defined; otherwise they read 0.

package read_return_router_pkg;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   receive_id;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] read_data;
  } read_return_t;
endpackage

module read_return_router
  import read_return_router_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int NUM_RX      = 4,
  parameter int RX_BASE     = 7,
  parameter int HALT_MARGIN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  read_return_t             read_back,
  output logic                     halt,
  output read_return_t             out_ret,
  output logic [NUM_RX-1:0]        out_valid,
  input  logic [NUM_RX-1:0]        out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic                     bad_id,
  output logic [15:0]              drop_count,
  output logic [31:0]              ret_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] HALT_OCC = OCC_W'(DEPTH - HALT_MARGIN);
  localparam logic [ID_W-1:0]  BASE_ID  = ID_W'(RX_BASE);

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e           state_q, state_d;
  read_return_t     mem_q [DEPTH];
  read_return_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             halt_q, halt_d;
  logic             overflow_q, overflow_d;
  logic             bad_id_q, bad_id_d;

  read_return_t     head;
  logic [ID_W-1:0]  head_idx;
  logic             head_mapped;
  logic             full, push, push_drop, pop, deliver, bad_pop;

  // Head entry and its receiver index; the subtraction wraps at ID width so IDs below the base become unmapped.
  assign head        = mem_q[rd_ptr_q];
  assign head_idx    = head.receive_id - BASE_ID;
  assign head_mapped = (32'(head_idx) < 32'(NUM_RX));

  // Head FSM: present the head, decide the pop, then derive occupancy and the next state from it.
  always_comb begin
    state_d   = state_q;
    out_valid = '0;
    out_ret   = '0;
    pop       = 1'b0;
    deliver   = 1'b0;
    bad_pop   = 1'b0;
    case (state_q)
      IDLE: begin
      end
      PRESENT: begin
        out_ret       = head;
        out_ret.valid = head_mapped;
        for (int k = 0; k < NUM_RX; k++) begin
          if (head_mapped && (32'(head_idx) == 32'(k))) out_valid[k] = 1'b1;
        end
        if (!head_mapped) begin
          pop     = 1'b1;
          bad_pop = 1'b1;
        end else if (|(out_valid & out_ready)) begin
          pop     = 1'b1;
          deliver = 1'b1;
        end
      end
      default: begin
      end
    endcase
    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    full      = (occ_q == FULL_OCC);
    push      = read_back.valid && (!full || pop);
    push_drop = read_back.valid && !push;
    occ_d     = occ_q + OCC_W'(push) - OCC_W'(pop);
    state_d   = (occ_d != '0) ? PRESENT : IDLE;
  end

  // Storage, pointers, early-warning halt and sticky error flags.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = read_back;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    halt_d     = (occ_d >= HALT_OCC);
    overflow_d = overflow_q | push_drop;
    bad_id_d   = bad_id_q | bad_pop;
  end

  // State registers; reset discards every held entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
      bad_id_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      halt_q     <= halt_d;
      overflow_q <= overflow_d;
      bad_id_q   <= bad_id_d;
      mem_q      <= mem_d;
    end
  end

  assign halt      = halt_q;
  assign occupancy = occ_q;
  assign overflow  = overflow_q;
  assign bad_id    = bad_id_q;

`ifdef READ_RETURN_ROUTER_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [31:0] ret_q, ret_d;
  logic [16:0] drop_sum;

  // Saturating statistics; an overflow drop and a bad-ID drop can land on the same edge.
  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(push_drop) + 17'(bad_pop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ret_d    = (deliver && (ret_q != '1)) ? ret_q + 32'd1 : ret_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
      ret_q  <= '0;
    end else begin
      drop_q <= drop_d;
      ret_q  <= ret_d;
    end
  end

  assign drop_count = drop_q;
  assign ret_count  = ret_q;
`else
  assign drop_count = '0;
  assign ret_count  = '0;
`endif
endmodule

// File: tb/tb_read_return_router.sv
// Bench for read_return_router: directed vector table, hand-written corner sequences and a randomized run
// checked every cycle against a queue-based reference model of the routing rules.
module tb_read_return_router;
  import read_return_router_pkg::*;

  localparam int DEPTH       = 8;
  localparam int NUM_RX      = 4;
  localparam int RX_BASE     = 7;
  localparam int HALT_MARGIN = 3;
`ifdef READ_RETURN_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  read_return_t  read_back;
  logic          halt;
  read_return_t  out_ret;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [3:0]    occupancy;
  logic          overflow;
  logic          bad_id;
  logic [15:0]   drop_count;
  logic [31:0]   ret_count;

  read_return_router #(
    .DEPTH(DEPTH), .NUM_RX(NUM_RX), .RX_BASE(RX_BASE), .HALT_MARGIN(HALT_MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .read_back(read_back), .halt(halt), .out_ret(out_ret),
    .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy),
    .overflow(overflow), .bad_id(bad_id), .drop_count(drop_count), .ret_count(ret_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a queue of held returns plus flags and counters.
  read_return_t mq[$];
  bit  m_halt, m_ovf, m_bad;
  int  m_drop, m_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int rx_index(input logic [3:0] id);
    return (int'(id) - RX_BASE) & ((1 << ID_W) - 1);
  endfunction

  function automatic read_return_t mkrb(input bit v, input logic [3:0] id, input logic [15:0] addr);
    read_return_t r;
    r.valid        = v;
    r.receive_id   = id;
    r.read_address = addr;
    r.read_data    = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_halt = 0; m_ovf = 0; m_bad = 0; m_drop = 0; m_ret = 0;
  endtask

  // Compare every DUT output against what the model's queue implies.
  task automatic check_model();
    read_return_t er;
    logic [3:0]   ev;
    int           idx;
    er = '0;
    ev = '0;
    if (mq.size() > 0) begin
      idx = rx_index(mq[0].receive_id);
      er  = mq[0];
      er.valid = (idx < NUM_RX);
      if (idx < NUM_RX) ev = 4'(1 << idx);
    end
    chk("out_valid", out_valid, ev);
    chk("out_ret", out_ret, er);
    chk("occupancy", occupancy, mq.size());
    chk("halt", halt, m_halt);
    chk("overflow", overflow, m_ovf);
    chk("bad_id", bad_id, m_bad);
    chk("drop_count", drop_count, STATS ? m_drop : 0);
    chk("ret_count", ret_count, STATS ? m_ret : 0);
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input read_return_t rb, input logic [3:0] rdy);
    bit popped;
    bit accept;
    int idx;
    popped = 0;
    accept = 0;
    if (mq.size() > 0) begin
      idx = rx_index(mq[0].receive_id);
      if (idx >= NUM_RX) begin
        popped = 1; m_bad = 1; m_drop++;
      end else if (rdy[idx]) begin
        popped = 1; m_ret++;
      end
    end
    if (rb.valid) begin
      if (mq.size() < DEPTH || popped) accept = 1;
      else begin
        m_ovf = 1; m_drop++;
      end
    end
    if (popped) void'(mq.pop_front());
    if (accept) mq.push_back(rb);
    if (m_drop > 65535) m_drop = 65535;
    m_halt = (mq.size() >= DEPTH - HALT_MARGIN);
  endtask

  // One cycle: entered at a falling edge, checks outputs, drives inputs, follows the rising edge.
  task automatic step(input read_return_t rb, input logic [3:0] rdy);
    check_model();
    read_back = rb;
    out_ready = rdy;
    @(posedge clk);
    model_edge(rb, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    read_back = '0;
    out_ready = '0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [3:0]  rdy;
    logic [3:0]  e_valid;
    int          e_occ;
    logic [15:0] e_addr;
    int          e_ret;
  } vec_t;

  vec_t tbl[13];
  int   cnt;

  initial begin
    tbl[0]  = '{1, 4'd8,  16'd3,  4'hF, 4'b0000, 0, 16'd0,  0};
    tbl[1]  = '{0, 4'd0,  16'd0,  4'hF, 4'b0010, 1, 16'd3,  0};
    tbl[2]  = '{0, 4'd0,  16'd0,  4'hF, 4'b0000, 0, 16'd0,  1};
    tbl[3]  = '{1, 4'd7,  16'd10, 4'h0, 4'b0000, 0, 16'd0,  1};
    tbl[4]  = '{1, 4'd10, 16'd11, 4'h0, 4'b0001, 1, 16'd10, 1};
    tbl[5]  = '{1, 4'd9,  16'd12, 4'h0, 4'b0001, 2, 16'd10, 1};
    tbl[6]  = '{1, 4'd8,  16'd13, 4'h0, 4'b0001, 3, 16'd10, 1};
    tbl[7]  = '{0, 4'd0,  16'd0,  4'h0, 4'b0001, 4, 16'd10, 1};
    tbl[8]  = '{0, 4'd0,  16'd0,  4'hF, 4'b0001, 4, 16'd10, 1};
    tbl[9]  = '{0, 4'd0,  16'd0,  4'hF, 4'b1000, 3, 16'd11, 2};
    tbl[10] = '{0, 4'd0,  16'd0,  4'hF, 4'b0100, 2, 16'd12, 3};
    tbl[11] = '{0, 4'd0,  16'd0,  4'hF, 4'b0010, 1, 16'd13, 4};
    tbl[12] = '{0, 4'd0,  16'd0,  4'hF, 4'b0000, 0, 16'd0,  5};

    rst       = 1'b1;
    read_back = '0;
    out_ready = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, single routing, stall and ordering.
    chk("reset_occ", occupancy, 0);
    chk("reset_halt", halt, 0);
    for (int i = 0; i < 13; i++) begin
      chk("tbl_valid", out_valid, tbl[i].e_valid);
      chk("tbl_occ", occupancy, tbl[i].e_occ);
      chk("tbl_addr", out_ret.read_address, tbl[i].e_addr);
      chk("tbl_ret", ret_count, STATS ? tbl[i].e_ret : 0);
      step(mkrb(tbl[i].v, tbl[i].id, tbl[i].addr), tbl[i].rdy);
    end

    // Halt and overflow: nine back-to-back pushes with nobody ready.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 4) chk("halt_after4", halt, 0);
      if (i == 5) chk("halt_after5", halt, 1);
      step(mkrb(1, 4'(7 + (i % 4)), 16'(100 + i)), 4'h0);
    end
    chk("ovf_occ", occupancy, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, STATS ? 1 : 0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (|out_valid) cnt++;
      step(mkrb(0, 4'd0, 16'd0), 4'hF);
    end
    chk("drain_count", cnt, 8);

    // Bad ID followed by a valid one.
    do_reset();
    step(mkrb(1, 4'd3, 16'd50), 4'hF);
    chk("bad_head_valid", out_valid, 0);
    step(mkrb(1, 4'd7, 16'd51), 4'hF);
    chk("bad_flag", bad_id, 1);
    chk("bad_drop", drop_count, STATS ? 1 : 0);
    chk("bad_next_valid", out_valid, 4'b0001);
    chk("bad_next_addr", out_ret.read_address, 16'd51);
    step(mkrb(0, 4'd0, 16'd0), 4'hF);
    step(mkrb(0, 4'd0, 16'd0), 4'hF);

    // Full boundary: sustained push and pop at occupancy 8.
    do_reset();
    for (int i = 0; i < 8; i++) step(mkrb(1, 4'(7 + (i % 4)), 16'(200 + i)), 4'h0);
    for (int i = 0; i < 20; i++) step(mkrb(1, 4'(7 + (i % 4)), 16'(300 + i)), 4'hF);
    chk("full_occ", occupancy, 8);
    chk("full_ovf", overflow, 0);
    chk("full_ret", ret_count, STATS ? 20 : 0);

    // Asynchronous reset with five entries held.
    do_reset();
    for (int i = 0; i < 5; i++) step(mkrb(1, 4'd8, 16'(400 + i)), 4'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_halt", halt, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(mkrb(1, 4'd9, 16'd77), 4'hF);
    chk("arst_next_valid", out_valid, 4'b0100);
    chk("arst_next_addr", out_ret.read_address, 16'd77);
    step(mkrb(0, 4'd0, 16'd0), 4'hF);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] id;
      logic [3:0] rdy;
      int mode;
      mode = (i / 100) % 3;
      id   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(6, 11));
      if (mode == 0)      rdy = 4'($urandom);
      else if (mode == 1) rdy = ($urandom_range(0, 9) == 0) ? 4'hF : 4'h0;
      else                rdy = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      step(mkrb($urandom_range(0, 9) < 6, id, 16'($urandom)), rdy);
    end
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
